// File: rtl/pe_code_capture_fifo.sv
// pe_code_capture_fifo: captures priority-encoder code events
// into a small FIFO with valid/ready output and drop counting.
module pe_code_capture_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     y0,
  input  logic                     y1,
  input  logic                     v,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_code,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [1:0]    s_code;
  logic [1:0]    p_code;
  logic          s_v;
  logic          p_v;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ev;
  logic          pop;
  logic          push;
  logic          drop;

  // a new request is v rising, or the code moving while v stays high
  assign ev   = s_v && (!p_v || (s_code != p_code));
  assign pop  = out_valid && out_ready;
  assign push = ev && (!full || pop);
  assign drop = ev && full && !pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == DEPTH_C);
  assign out_valid = !empty;
  assign out_code  = mem[rd_ptr];
  assign count     = cnt;

  // two-deep sample pipeline of the encoder outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_code <= '0;
      p_code <= '0;
      s_v    <= 1'b0;
      p_v    <= 1'b0;
    end else begin
      s_code <= {y1, y0};
      s_v    <= v;
      p_code <= s_code;
      p_v    <= s_v;
    end
  end

  // storage; cleared on reset so the head reads 0 when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= s_code;
    end
  end

  // pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // saturating drop counter and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      overflow <= 1'b1;
    end
  end

endmodule

// File: doc/pe_code_capture_fifo.md
Name: pe_code_capture_fifo

Overview:
- Downstream consumer of the 4x2 priority encoder (a0..a3 -> y1,y0,v).
- Samples the encoder outputs every clock and detects new-request events: v rising, or a code change while v is high.
- Queues each event's 2-bit code in a small FIFO and presents it on a valid/ready output handshake.
- Counts events dropped on overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- y0  input  1  encoder code bit 0.
- y1  input  1  encoder code bit 1.
- v  input  1  encoder valid (any input active).
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_code  output  2  head entry code {y1,y0}.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- drop_cnt  output  CNT_W  events lost to overflow; saturating.
- overflow  output  1  sticky; set on first drop.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - out_valid=0, out_code=0, count=0, full=0, empty=1, drop_cnt=0, overflow=0.
  - Sample and previous-sample registers cleared to 0, so a v already high at release counts as a rising edge.
- Sampling:
  - Each posedge registers {y1,y0} into s_code and v into s_v.
  - The prior s_code and s_v move into p_code and p_v.
- Event:
  - event = s_v && (!p_v || s_code != p_code), combinational from the sample registers.
  - A steady held code produces exactly one event.
  - v low produces no event, whatever the value of y.
- Push: on a posedge with event, s_code is written at the write pointer.
- Pop: on a posedge with out_valid && out_ready, the read pointer advances.
- Pointers wrap modulo DEPTH.
- Latency: input stable before edge k -> sampled at edge k -> pushed at edge k+1 -> out_valid=1 after edge k+1 (2 clocks, empty FIFO).
- Output:
  - out_code = entry at the read pointer, driven straight from storage (no extra register).
  - out_valid = !empty.
  - out_code is stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - Full, event and pop in the same cycle: both occur, count unchanged, no drop.
  - Empty with event: push only (out_valid=0, so no pop); count goes 0 -> 1.
  - Partial, push and pop together: count unchanged, order preserved.
- Overflow:
  - Full, event and no pop: the event is discarded and storage is unchanged.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - overflow sets and stays set until reset.
- Ordering: strict FIFO; no entry is ever duplicated or reordered.
- Reset mid-operation: all queued entries and pending samples are discarded immediately, and outputs take their reset values asynchronously.
- out_ready while empty is ignored.
- No X on outputs after reset.

Test Plan:
1. Reset, then v=1, {y1,y0}=2'b10 held for 10 cycles, out_ready=1 -> one entry with out_code=2 and out_valid high for exactly 1 cycle, 2 clocks after the input change; drop_cnt=0.
2. out_ready=0, with codes 0,1,2,3 each applied for 2 cycles with v=1 -> count=4, full=1; then out_ready=1 -> pops 0,1,2,3 in order, empty=1.
3. DEPTH=4 full, out_ready=0, two further code changes -> count stays 4, drop_cnt=2, overflow=1; drain returns the original 4 codes.
4. Full FIFO, a new event in the same cycle as out_ready=1 -> count stays 4, drop_cnt unchanged, new code lands at the tail.
5. v toggles 1,0,1 with code fixed at 3, and y changes while v=0 -> two entries of code 3; nothing captured while v=0.
6. rst_n asserted low mid-stream with 3 entries queued -> count=0, out_valid=0, overflow=0 immediately, with no clock; after release, the first new event appears with 2-clock latency.
